rw_port_arbiter: RTL
====================

// Module: rw_port_arbiter
// PURPOSE
//  Drives a single-port memory from two requesters, a writer and a reader, with
//  level-held req/ack handshakes. mem_wr_en and mem_rd_en are never high in the
//  same cycle. Returns read data with a valid strobe.
//  Counts write/read collisions and flags when the count reaches a limit.
//  Sits between the traffic generators and the memory model in the dvfeature benches.
// PARAMETERS
//  AW         8   address width
//  DW         16  data width
//  RD_LAT     1   memory read latency in cycles (legal 1..4)
//  CNT_W      8   collision counter width
//  ERR_LIMIT  14  conflict_limit asserts when conflict_cnt >= ERR_LIMIT
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous reset, active low
//  wr_req         in   1     write request; held until wr_ack
//  wr_addr        in   AW    write address; stable while wr_req is high
//  wr_data        in   DW    write data; stable while wr_req is high
//  wr_ack         out  1     1-cycle pulse: write issued this cycle
//  rd_req         in   1     read request; held until rd_ack
//  rd_addr        in   AW    read address; stable while rd_req is high
//  rd_ack         out  1     1-cycle pulse: read issued this cycle
//  rd_valid       out  1     1-cycle pulse: rd_data is valid
//  rd_data        out  DW    read data, captured from mem_rdata
//  mem_wr_en      out  1     memory write strobe
//  mem_rd_en      out  1     memory read strobe
//  mem_addr       out  AW    memory address
//  mem_wdata      out  DW    memory write data
//  mem_rdata      in   DW    valid RD_LAT cycles after the mem_rd_en cycle
//  conflict_cnt   out  CNT_W collision count, saturating
//  conflict_limit out  1     conflict_cnt >= ERR_LIMIT
// BEHAVIOUR
//  - All outputs are registered. Async reset clears all outputs and the counter,
//    sets state IDLE and sets priority to write-first.
//  - FSM states: IDLE, WRITE, READ, RD_WAIT.
//  - IDLE, wr_req only: next state WRITE.
//  - IDLE, rd_req only: next state READ.
//  - IDLE, both requests: a collision. Grant the side not granted at the last
//    collision; the first collision after reset grants write. conflict_cnt += 1,
//    saturating at 2^CNT_W-1.
//  - IDLE, no request: stay in IDLE.
//  - WRITE (exactly 1 cycle): mem_wr_en=1, wr_ack=1, mem_addr=wr_addr,
//    mem_wdata=wr_data. Next state IDLE.
//  - READ (exactly 1 cycle): mem_rd_en=1, rd_ack=1, mem_addr=rd_addr.
//    Next state RD_WAIT.
//  - RD_WAIT: wait RD_LAT cycles with no issue. Capture mem_rdata into rd_data.
//    rd_valid=1 in cycle R+RD_LAT+1, where R is the READ cycle. Next state IDLE.
//  - Throughput: 1 write per 2 cycles; 1 read per RD_LAT+2 cycles.
//    Requests arriving during READ or RD_WAIT wait in IDLE arbitration.
//  - Requester drops req after sampling ack. IDLE evaluates the next cycle, so no
//    double issue. A req still high after ack is treated as a new request.
//  - mem_addr and mem_wdata hold their last value when idle. rd_data holds until
//    the next rd_valid.
//  - Reset mid-read: the pending read is discarded. No rd_valid after reset release.
//  - Embedded checks under `ifndef SYNTHESIS, each with pass/fail action blocks:
//    * never (mem_wr_en && mem_rd_en);
//    * wr_ack implies mem_wr_en; rd_ack implies mem_rd_en;
//    * rd_valid count equals rd_ack count once idle.
//    On failure: $error with %m, and increment assert_fail_cnt (bench-visible).
// STRUCTURE
//  - Package rw_arb_pkg: state enum typedef (IDLE/WRITE/READ/RD_WAIT) and the
//    default AW, DW, RD_LAT, ERR_LIMIT constants.
//  - Sub-module sat_counter (WIDTH, inc, count): the saturating collision counter.
//  - The read-latency down-counter is inline.
// TESTING
//  1. Write 0xBEEF to 0x12 -> mem_wr_en and wr_ack high exactly 1 cycle together;
//     mem_addr=0x12, mem_wdata=0xBEEF; conflict_cnt=0.
//  2. RD_LAT=2, read 0x34, model returns 0x5A5A -> rd_valid 3 cycles after the
//     mem_rd_en cycle; rd_data=0x5A5A; one rd_valid per rd_ack.
//  3. wr_req and rd_req high together from reset -> issue order W,R,W,R;
//     conflict_cnt increments once per collision grant.
//  4. 20 back-to-back collisions (ERR_LIMIT=14) -> conflict_cnt=20;
//     conflict_limit rises in the cycle after the count reaches 14;
//     assert_fail_cnt=0; strobes never overlap.
//  5. CNT_W=4, 20 collisions -> conflict_cnt saturates at 15 and holds.
//  6. rst_n low during RD_WAIT -> all outputs 0 immediately; after release no
//     rd_valid, conflict_cnt=0, first collision grants write.

Source files
------------

// File: rtl/rw_arb_pkg.sv
// Shared types and default parameters for the read/write port arbiter.
package rw_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        RD_WAIT = 2'd3
    } arb_state_e;

    localparam int AW_DEF        = 8;
    localparam int DW_DEF        = 16;
    localparam int RD_LAT_DEF    = 1;
    localparam int CNT_W_DEF     = 8;
    localparam int ERR_LIMIT_DEF = 14;

endpackage

// File: rtl/rw_port_arbiter_sat_counter.sv
// Saturating up-counter used to tally write/read collisions.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rw_port_arbiter.sv
// Arbitrates one writer and one reader onto a single-port memory using
// level-held req/ack handshakes, alternating priority on collisions.
module rw_port_arbiter
    import rw_arb_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ERR_LIMIT = ERR_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    output logic             wr_ack,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_ack,
    output logic             rd_valid,
    output logic [DW-1:0]    rd_data,
    output logic             mem_wr_en,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic             conflict_limit
);

    localparam int          LAT_W   = 2;
    localparam logic [31:0] LIMIT32 = 32'(ERR_LIMIT);

    arb_state_e       state_q;
    logic             prio_rd_q;
    logic             prio_rd_d;
    logic [LAT_W-1:0] lat_q;
    logic             wr_ack_q;
    logic             rd_ack_q;
    logic             rd_valid_q;
    logic [DW-1:0]    rd_data_q;
    logic             mem_wr_en_q;
    logic             mem_rd_en_q;
    logic [AW-1:0]    mem_addr_q;
    logic [DW-1:0]    mem_wdata_q;
    logic             conflict_limit_q;
    logic [CNT_W-1:0] cnt;
    logic             collision;
    logic             grant_wr;

    // On a collision the side not favoured last time wins; prio_rd_q=0 means write wins next.
    assign collision = (state_q == IDLE) && wr_req && rd_req;
    assign grant_wr  = wr_req && !(rd_req && prio_rd_q);
    assign prio_rd_d = collision ? !prio_rd_q : prio_rd_q;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_conflict_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (collision),
        .count(cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_rd_q   <= 1'b0;
            lat_q       <= '0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            prio_rd_q   <= prio_rd_d;
            case (state_q)
                IDLE: begin
                    if (grant_wr) begin
                        state_q     <= WRITE;
                        mem_wr_en_q <= 1'b1;
                        wr_ack_q    <= 1'b1;
                        mem_addr_q  <= wr_addr;
                        mem_wdata_q <= wr_data;
                    end else if (rd_req) begin
                        state_q     <= READ;
                        mem_rd_en_q <= 1'b1;
                        rd_ack_q    <= 1'b1;
                        mem_addr_q  <= rd_addr;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                READ: begin
                    state_q <= RD_WAIT;
                    lat_q   <= LAT_W'(RD_LAT - 1);
                end
                RD_WAIT: begin
                    // Last wait cycle is the one in which mem_rdata is valid.
                    if (lat_q == '0) begin
                        rd_data_q  <= mem_rdata;
                        rd_valid_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_limit_q <= 1'b0;
        end else begin
            conflict_limit_q <= (32'(cnt) >= LIMIT32);
        end
    end

    assign wr_ack         = wr_ack_q;
    assign rd_ack         = rd_ack_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign mem_wr_en      = mem_wr_en_q;
    assign mem_rd_en      = mem_rd_en_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign conflict_cnt   = cnt;
    assign conflict_limit = conflict_limit_q;

`ifndef SYNTHESIS
    int fail_overlap_cnt = 0;
    int fail_ack_cnt     = 0;
    int fail_bal_cnt     = 0;
    int pass_overlap_cnt = 0;
    int pass_ack_cnt     = 0;
    int pass_bal_cnt     = 0;
    int rd_ack_seen;
    int rd_valid_seen;
    int assert_fail_cnt;

    assign assert_fail_cnt = fail_overlap_cnt + fail_ack_cnt + fail_bal_cnt;

    // A pending read is dropped by reset, so the balance restarts with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack_seen   <= 0;
            rd_valid_seen <= 0;
        end else begin
            rd_ack_seen   <= rd_ack_seen + 32'(rd_ack_q);
            rd_valid_seen <= rd_valid_seen + 32'(rd_valid_q);
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            a_no_overlap: assert (!(mem_wr_en_q && mem_rd_en_q))
                pass_overlap_cnt <= pass_overlap_cnt + 1;
            else begin
                $error("%m: mem_wr_en and mem_rd_en high together");
                fail_overlap_cnt <= fail_overlap_cnt + 1;
            end
            a_ack_strobe: assert ((!wr_ack_q || mem_wr_en_q) && (!rd_ack_q || mem_rd_en_q))
                pass_ack_cnt <= pass_ack_cnt + 1;
            else begin
                $error("%m: ack without matching memory strobe");
                fail_ack_cnt <= fail_ack_cnt + 1;
            end
            a_rd_balance: assert ((state_q != IDLE) || (rd_ack_seen == rd_valid_seen + 32'(rd_valid_q)))
                pass_bal_cnt <= pass_bal_cnt + 1;
            else begin
                $error("%m: rd_valid count differs from rd_ack count while idle");
                fail_bal_cnt <= fail_bal_cnt + 1;
            end
        end
    end
`endif

endmodule
